// File: rtl/seq_detect_param_pkg.sv
// Shared constants for the parametrised serial sequence detector.
// Mode encodings for cfg_overlap and the supported pattern-length range.
package seq_detect_pkg;

    localparam logic MODE_OVERLAP = 1'b1;
    localparam logic MODE_NONOVL  = 1'b0;

    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 32;

    function automatic bit pat_len_ok(input int n);
        return (n >= PAT_LEN_MIN) && (n <= PAT_LEN_MAX);
    endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Stream, configuration and status bundle for seq_detect_param.
// The master drives bits and configuration; the detector (slave) returns match status.
interface seq_detect_param_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               cin;
    logic               cin_vld;
    logic               cfg_load;
    logic [PAT_LEN-1:0] cfg_pattern;
    logic [PAT_LEN-1:0] cfg_mask;
    logic               cfg_overlap;
    logic               cnt_clr;
    logic               cout;
    logic [CNT_W-1:0]   hit_cnt;
    logic               armed;

    modport master (
        output cin, cin_vld, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
        input  cout, hit_cnt, armed
    );

    modport slave (
        input  cin, cin_vld, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, cnt_clr,
        output cout, hit_cnt, armed
    );
endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-sequence detector: masked match of a loadable PAT_LEN-bit pattern
// against the valid-qualified stream, with overlap control and a saturating hit count.
module seq_detect_param
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter int                 CNT_W   = 8,
    parameter logic [PAT_LEN-1:0] RST_PAT = '1
) (
    input  logic               clk,
    input  logic               rst,
    seq_detect_param_if.slave  bus
);
    localparam int FILL_W = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

    generate
        if (!pat_len_ok(PAT_LEN)) begin : g_bad_len
            $error("seq_detect_param: PAT_LEN out of range");
        end
    endgenerate

    logic [PAT_LEN-2:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [PAT_LEN-1:0] pattern_q, pattern_d;
    logic [PAT_LEN-1:0] mask_q, mask_d;
    logic               overlap_q, overlap_d;

    logic               consume;
    logic               armed;
    logic [PAT_LEN-1:0] window;
    logic               hit;

    // The incoming bit completes the window, so a match is reported in the same cycle.
    assign consume = bus.cin_vld & ~bus.cfg_load;
    assign armed   = (fill_q == FILL_MAX);
    assign window  = {hist_q, bus.cin};
    assign hit     = consume & armed & (((window ^ pattern_q) & mask_q) == '0);

    always_comb begin
        hist_d    = hist_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        mask_d    = mask_q;
        overlap_d = overlap_q;
        if (bus.cfg_load) begin
            pattern_d = bus.cfg_pattern;
            mask_d    = bus.cfg_mask;
            overlap_d = bus.cfg_overlap;
            fill_d    = '0;
        end else if (consume) begin
            hist_d = window[PAT_LEN-2:0];
            // Non-overlap restarts the fill so the next match needs PAT_LEN fresh bits.
            if (hit && (overlap_q == MODE_NONOVL)) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= RST_PAT;
            mask_q    <= '1;
            overlap_q <= MODE_OVERLAP;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            overlap_q <= overlap_d;
        end
    end

    logic [CNT_W-1:0] cnt;

    sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .clr (bus.cnt_clr),
        .cnt (cnt)
    );

    assign bus.cout    = hit;
    assign bus.hit_cnt = cnt;
    assign bus.armed   = armed;
endmodule

// File: tb/tb_seq_detect_param.sv
// Directed and randomized bench for seq_detect_param against a bit-queue reference model.
module tb_seq_detect_param;
    localparam int PL   = 4;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_detect_param_if #(.PAT_LEN(PL), .CNT_W(CW)) sif ();

    seq_detect_param #(.PAT_LEN(PL), .CNT_W(CW), .RST_PAT(4'b1111)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: every consumed bit, plus count of bits since the last restart.
    logic [PL-1:0] m_pat, m_mask;
    logic          m_ovl;
    int            m_cnt, m_fresh;
    bit            m_bits[$];

    task automatic model_reset();
        m_pat   = 4'b1111;
        m_mask  = '1;
        m_ovl   = 1'b1;
        m_cnt   = 0;
        m_fresh = 0;
        m_bits.delete();
    endtask

    function automatic logic model_hit();
        if (!sif.cin_vld || sif.cfg_load || m_fresh < PL - 1) return 1'b0;
        for (int k = 0; k < PL; k++) begin
            bit b;
            b = (k == 0) ? sif.cin : m_bits[m_bits.size() - k];
            if (m_mask[k] && (b != m_pat[k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive, compare at the falling edge, advance the model at the rising edge.
    task automatic cyc(input logic c, input logic v, input logic ld, input logic cl, input int exp_c);
        logic h;
        sif.cin      = c;
        sif.cin_vld  = v;
        sif.cfg_load = ld;
        sif.cnt_clr  = cl;
        @(negedge clk);
        h = model_hit();
        check("cout", sif.cout, h);
        check("armed", sif.armed, (m_fresh == PL - 1));
        check("hit_cnt", sif.hit_cnt, m_cnt);
        if (exp_c >= 0) check("cout_directed", sif.cout, exp_c[0]);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (cl) m_cnt = 0;
            else if (h && m_cnt < CMAX) m_cnt++;
            if (ld) begin
                m_pat   = sif.cfg_pattern;
                m_mask  = sif.cfg_mask;
                m_ovl   = sif.cfg_overlap;
                m_fresh = 0;
            end else if (v) begin
                m_bits.push_back(c);
                if (m_bits.size() > 64) void'(m_bits.pop_front());
                if (h && !m_ovl) m_fresh = 0;
                else if (m_fresh < PL - 1) m_fresh++;
            end
        end
        #1;
    endtask

    task automatic load(input logic [PL-1:0] pat, input logic [PL-1:0] mask, input logic ovl, input logic cl);
        sif.cfg_pattern = pat;
        sif.cfg_mask    = mask;
        sif.cfg_overlap = ovl;
        cyc(1'b1, 1'b1, 1'b1, cl, 0);
    endtask

    // Bits, valids and directed cout expectations, first element in the MSB of n.
    task automatic run(input logic [15:0] bits, input logic [15:0] vlds, input logic [15:0] exps, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(bits[i], vlds[i], 1'b0, 1'b0, int'(exps[i]));
    endtask

    task automatic rst_cyc();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst             = 1'b1;
        sif.cin         = 1'b0;
        sif.cin_vld     = 1'b0;
        sif.cfg_load    = 1'b0;
        sif.cfg_pattern = '0;
        sif.cfg_mask    = '0;
        sif.cfg_overlap = 1'b0;
        sif.cnt_clr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check("rst_hit_cnt", sif.hit_cnt, 0);
        check("rst_armed", sif.armed, 0);

        // Reset defaults: 1111 pattern, hit on the fourth one.
        run(16'b1111, 16'b1111, 16'b0001, 4);
        check("t1_hit_cnt", sif.hit_cnt, 1);

        // Overlap versus non-overlap on six ones.
        load(4'b1111, 4'b1111, 1'b1, 1'b1);
        run(16'b111111, 16'b111111, 16'b000111, 6);
        check("t2_ovl_cnt", sif.hit_cnt, 3);
        load(4'b1111, 4'b1111, 1'b0, 1'b1);
        run(16'b111111, 16'b111111, 16'b000100, 6);
        check("t2_nonovl_cnt", sif.hit_cnt, 1);

        // Invalid cycles are transparent to the sequence.
        load(4'b1011, 4'b1111, 1'b1, 1'b1);
        run(16'b11011111, 16'b10110001, 16'b00000001, 8);
        check("t3_cnt", sif.hit_cnt, 1);

        // Masked compare, non-overlap.
        load(4'b1001, 4'b1001, 1'b0, 1'b1);
        run(16'b1111_1001_0111, 16'hFFF, 16'b0001_0001_0000, 12);
        check("t4_cnt", sif.hit_cnt, 2);

        // Reconfiguration and reset discard a partial match.
        load(4'b1111, 4'b1111, 1'b1, 1'b0);
        run(16'b111, 16'b111, 16'b000, 3);
        load(4'b1111, 4'b1111, 1'b1, 1'b0);
        run(16'b1111, 16'b1111, 16'b0001, 4);
        load(4'b1111, 4'b1111, 1'b1, 1'b0);
        run(16'b111, 16'b111, 16'b000, 3);
        rst_cyc();
        check("t5_rst_cnt", sif.hit_cnt, 0);
        run(16'b1111, 16'b1111, 16'b0001, 4);

        // Saturation at 3 and clear winning over a coincident hit.
        load(4'b1111, 4'b1111, 1'b1, 1'b1);
        check("t6_clr_cnt", sif.hit_cnt, 0);
        run(16'b11111111, 16'hFF, 16'b00011111, 8);
        check("t6_sat_cnt", sif.hit_cnt, CMAX);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1);
        check("t6_clr_hit_cnt", sif.hit_cnt, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst = 1'b1;
                cyc(1'($urandom), 1'($urandom), 1'b0, 1'b0, -1);
                rst = 1'b0;
            end else if (r < 7) begin
                sif.cfg_pattern = PL'($urandom);
                sif.cfg_mask    = ($urandom_range(0, 3) == 0) ? PL'($urandom) : '1;
                sif.cfg_overlap = 1'($urandom);
                cyc(1'($urandom), 1'($urandom), 1'b1, ($urandom_range(0, 19) == 0), -1);
            end else begin
                cyc(1'($urandom), ($urandom_range(0, 9) < 8), 1'b0, ($urandom_range(0, 29) == 0), -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
